// File: rtl/wac_pkg.sv
// wac_pkg: shared FSM state encoding, byte-order constants and BRAM data width for adc_acq_ctrl
package wac_pkg;
   typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, HOLD, WRITE, DONE} state_e;
   localparam int   BRAM_DATA_W = 8;
   localparam logic BYTE_LO     = 1'b0;
   localparam logic BYTE_HI     = 1'b1;
endpackage

// File: rtl/acq_sclk_gen.sv
// acq_sclk_gen: runs FRAME_BITS sclk periods (low CLK_DIV, high CLK_DIV) after a start pulse, sclk idles high
module acq_sclk_gen #(
   parameter int FRAME_BITS = 16,
   parameter int CLK_DIV    = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start_i,
   output logic sclk_o,
   output logic rise_o,
   output logic last_o
);
   logic        run_q, sclk_q, half_end;
   logic [15:0] div_q;
   logic [7:0]  bit_q;
   assign half_end = run_q && div_q == 16'(CLK_DIV - 1);
   assign rise_o   = half_end && !sclk_q;
   assign last_o   = half_end && sclk_q && bit_q == 8'(FRAME_BITS - 1);
   assign sclk_o   = sclk_q;
   // half-period divider and bit counter; sclk stays high after the final period
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         run_q  <= 1'b0;
         sclk_q <= 1'b1;
         div_q  <= '0;
         bit_q  <= '0;
      end else if (start_i) begin
         run_q  <= 1'b1;
         sclk_q <= 1'b0;
         div_q  <= '0;
         bit_q  <= '0;
      end else if (half_end) begin
         div_q  <= '0;
         bit_q  <= bit_q + 8'(sclk_q);
         run_q  <= !last_o;
         sclk_q <= !sclk_q || last_o;
      end else if (run_q) begin
         div_q  <= div_q + 16'd1;
      end
endmodule

// File: rtl/adc_acq_ctrl.sv
// adc_acq_ctrl: multi-channel SPI ADC acquisition into BRAM port B; define ACQ_TESTPAT_EN to replace sdo with a counting pattern
module adc_acq_ctrl
   import wac_pkg::*;
#(
   parameter int N_CH       = 2,
   parameter int SAMPLE_W   = 12,
   parameter int FRAME_BITS = 16,
   parameter int CLK_DIV    = 2,
   parameter int QUIET      = 4,
   parameter int ADDR_W     = 12
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_i,
   input  logic                   stop_i,
   input  logic                   mode_i,
   input  logic [15:0]            n_samples_i,
   input  logic [N_CH-1:0]        sdo_i,
   output logic                   cs_n_o,
   output logic                   sclk_o,
   output logic [ADDR_W-1:0]      bram_addr_o,
   output logic [BRAM_DATA_W-1:0] bram_din_o,
   output logic                   bram_we_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   overflow_o,
   output logic [15:0]            frame_cnt_o
);
   localparam int NB = 2 * N_CH;
   state_e                 state_q;
   logic                   cs_n_q, mode_q, stop_q, we_q, busy_q, done_q, ovf_q;
   logic [15:0]            cnt_q, n_q, fc_q, fc_d, w_0, w_n;
   logic [ADDR_W:0]        addr_q;
   logic [BRAM_DATA_W-1:0] din_q, din_d;
   logic [3:0]             widx_q, widx_d;
   logic                   sg_start, rise, last, fin_d, ovf_d, stop_d;
   logic [SAMPLE_W-1:0]    samp [8];

   assign sg_start = state_q == CS_SETUP && cnt_q == 16'(CLK_DIV - 1);

   acq_sclk_gen #(.FRAME_BITS(FRAME_BITS), .CLK_DIV(CLK_DIV)) u_sclk (
      .clk(clk), .rst_n(rst_n), .start_i(sg_start), .sclk_o(sclk_o), .rise_o(rise), .last_o(last)
   );

   genvar i;
   for (i = 0; i < 8; i++) begin : g_ch
      if (i < N_CH) begin : g_on
`ifdef ACQ_TESTPAT_EN
         assign samp[i] = SAMPLE_W'(fc_q + 16'(i));
`else
         logic [SAMPLE_W-1:0] sh_q;
         // capture sdo on each sclk rise; older bits fall off the top
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) sh_q <= '0;
            else if (rise) sh_q <= SAMPLE_W'({sh_q, sdo_i[i]});
         assign samp[i] = sh_q;
`endif
      end else begin : g_off
         assign samp[i] = '0;
      end
   end

   assign fc_d   = fc_q + 16'd1;
   assign widx_d = widx_q + 4'd1;
   assign w_0    = 16'(samp[0]);
   assign w_n    = 16'(samp[widx_d[3:1]]);
   assign din_d  = widx_d[0] == BYTE_HI ? w_n[15:8] : w_n[7:0];
   assign fin_d  = !mode_q && fc_d == n_q;
   assign stop_d = stop_q || stop_i;
   // addr_q still holds the last written byte address when this is evaluated
   assign ovf_d  = !mode_q && int'(addr_q) + 1 + NB > 2 ** ADDR_W;

   // acquisition sequencer with registered outputs
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         cs_n_q  <= 1'b1;
         mode_q  <= 1'b0;
         stop_q  <= 1'b0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         n_q     <= '0;
         fc_q    <= '0;
         addr_q  <= '0;
         din_q   <= '0;
         widx_q  <= '0;
      end else begin
         done_q <= 1'b0;
         if (busy_q && stop_i) stop_q <= 1'b1;
         case (state_q)
            IDLE: if (start_i) begin
               mode_q <= mode_i;
               n_q    <= n_samples_i;
               addr_q <= '0;
               fc_q   <= '0;
               ovf_q  <= 1'b0;
               stop_q <= 1'b0;
               busy_q <= 1'b1;
               cnt_q  <= '0;
               if (!mode_i && n_samples_i == 16'd0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= CS_SETUP;
                  cs_n_q  <= 1'b0;
               end
            end
            CS_SETUP: begin
               cnt_q <= cnt_q + 16'd1;
               if (sg_start) state_q <= SHIFT;
            end
            SHIFT: if (last) begin
               state_q <= HOLD;
               cs_n_q  <= 1'b1;
               cnt_q   <= '0;
            end
            HOLD: begin
               cnt_q <= cnt_q + 16'd1;
               if (cnt_q == 16'(QUIET - 1)) begin
                  state_q <= WRITE;
                  we_q    <= 1'b1;
                  widx_q  <= '0;
                  din_q   <= w_0[7:0];
               end
            end
            WRITE: begin
               addr_q <= addr_q + 1'b1;
               widx_q <= widx_d;
               din_q  <= din_d;
               if (widx_q == 4'(NB - 1)) begin
                  we_q  <= 1'b0;
                  fc_q  <= fc_d;
                  cnt_q <= '0;
                  if (fin_d || stop_d || ovf_d) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     ovf_q   <= ovf_d && !fin_d && !stop_d;
                  end else begin
                     state_q <= CS_SETUP;
                     cs_n_q  <= 1'b0;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end

   assign cs_n_o      = cs_n_q;
   assign bram_addr_o = addr_q[ADDR_W-1:0];
   assign bram_din_o  = din_q;
   assign bram_we_o   = we_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign overflow_o  = ovf_q;
   assign frame_cnt_o = fc_q;
endmodule
